// File: rtl/bus85_pkg.sv
// rtl/bus85_pkg.sv - shared types, core85 defaults and helpers for the bus85 slave
package bus85_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        XFER = 2'd3
    } bus85_state_e;

    localparam int CORE85_ADDRSIZE = 16;
    localparam int CORE85_DATASIZE = 8;

    // Width of a port index; a single port still needs a one-bit index.
    function automatic int port_idx_w(input int ioports);
        return (ioports > 1) ? $clog2(ioports) : 1;
    endfunction

endpackage

// File: rtl/bus85_waitgen.sv
// rtl/bus85_waitgen.sv - wait-state counter driving the core85 READY line
// Ports: load starts a wait sequence, count advances it while waiting,
// ready is the registered READY output, done flags the last wait cycle.
module bus85_waitgen #(
    parameter int WAITS = 0
) (
    input  logic clk,
    input  logic rst_,
    input  logic load,
    input  logic count,
    output logic ready,
    output logic done
);

    localparam logic [2:0] WAITS_L = 3'(WAITS);

    logic [2:0] cnt;
    logic       ready_d;

    // READY drops on load and rises on the edge that consumes the last wait.
    // When neither load nor count is active (idle or aborted) it sits high.
    always_comb begin
        ready_d = 1'b1;
        if (load) begin
            ready_d = (WAITS == 0);
        end else if (count) begin
            ready_d = (cnt == 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt   <= '0;
            ready <= 1'b1;
        end else begin
            ready <= ready_d;
            if (load) begin
                cnt <= WAITS_L;
            end else if (count && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // With no wait states the counter is never used and done is always true.
    assign done = (WAITS == 0) || (cnt == 3'd1);

endmodule

// File: rtl/bus85_memif.sv
// rtl/bus85_memif.sv - core85 multiplexed-bus memory and I/O target with wait states
// Ports: clk/rst_ clock and async reset; ad_in/addr_hi/ale/iom_/rd_/wr_ bus
// inputs; ad_out/ad_oe read data and drive enable; ready to the core;
// io_in/io_out/io_wstb I/O port bank; cyc_err flags unselected/illegal access.
module bus85_memif
    import bus85_pkg::*;
#(
    parameter int ADDRSIZE = CORE85_ADDRSIZE,
    parameter int DATASIZE = CORE85_DATASIZE,
    parameter int MEMDEPTH = 1024,
    parameter int MEMBASE  = 0,
    parameter int WAITS    = 0,
    parameter int IOPORTS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [DATASIZE-1:0]           ad_in,
    input  logic [ADDRSIZE-DATASIZE-1:0]  addr_hi,
    input  logic                          ale,
    input  logic                          iom_,
    input  logic                          rd_,
    input  logic                          wr_,
    output logic [DATASIZE-1:0]           ad_out,
    output logic                          ad_oe,
    output logic                          ready,
    input  logic [IOPORTS*DATASIZE-1:0]   io_in,
    output logic [IOPORTS*DATASIZE-1:0]   io_out,
    output logic [IOPORTS-1:0]            io_wstb,
    output logic                          cyc_err
);

    localparam int MW = $clog2(MEMDEPTH);
    localparam int PW = port_idx_w(IOPORTS);
    localparam int AX = ADDRSIZE + 1;
    localparam int DX = DATASIZE + 1;

    // Range bounds carry one extra bit so a window ending at 2^ADDRSIZE
    // is representable and anything past it is simply never selected.
    localparam logic [ADDRSIZE:0] MEM_LO = AX'(MEMBASE);
    localparam logic [ADDRSIZE:0] MEM_HI = AX'(MEMBASE + MEMDEPTH);
    localparam logic [DATASIZE:0] IO_LIM = DX'(IOPORTS);

    bus85_state_e        state, state_d;
    logic [ADDRSIZE-1:0] addr_q;
    logic                iom_q;
    logic                wr_q;
    logic                mem_sel, io_sel, sel;
    logic                load, count, done, err_d, xfer_go, is_wr;
    logic [PW-1:0]       port;
    logic [MW-1:0]       mem_idx;
    logic [DATASIZE-1:0] io_rd;
    logic [DATASIZE-1:0] mem [MEMDEPTH];

    assign mem_sel = ({1'b0, addr_q} >= MEM_LO) && ({1'b0, addr_q} < MEM_HI);
    assign io_sel  = ({1'b0, addr_q[DATASIZE-1:0]} < IO_LIM);
    assign sel     = iom_q ? io_sel : mem_sel;
    assign port    = addr_q[PW-1:0];
    // MEMBASE is MEMDEPTH-aligned, so the offset is just the low address bits.
    assign mem_idx = addr_q[MW-1:0];

    // Direction is taken live in ADDR (zero-wait transfers happen there) and
    // from the latched copy once the cycle is waiting.
    assign is_wr = (state == ADDR) ? !wr_ : wr_q;

    always_comb begin
        io_rd = '0;
        for (int p = 0; p < IOPORTS; p++) begin
            if (port == PW'(p)) begin
                io_rd = io_in[p*DATASIZE +: DATASIZE];
            end
        end
    end

    bus85_waitgen #(
        .WAITS(WAITS)
    ) u_waitgen (
        .clk   (clk),
        .rst_  (rst_),
        .load  (load),
        .count (count),
        .ready (ready),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ALE overrides every state so a new address always aborts the old cycle.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        count   = 1'b0;
        err_d   = 1'b0;
        xfer_go = 1'b0;
        if (ale) begin
            state_d = ADDR;
        end else begin
            case (state)
                ADDR: begin
                    if (!rd_ && !wr_) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!rd_ || !wr_) begin
                        if (sel) begin
                            load = 1'b1;
                            if (WAITS == 0) begin
                                xfer_go = 1'b1;
                                state_d = XFER;
                            end else begin
                                state_d = WAIT;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                WAIT: begin
                    count = 1'b1;
                    if (done) begin
                        xfer_go = 1'b1;
                        state_d = XFER;
                    end
                end
                XFER: begin
                    if (rd_ && wr_) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            addr_q  <= '0;
            iom_q   <= 1'b0;
            wr_q    <= 1'b0;
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            io_out  <= '0;
            io_wstb <= '0;
            cyc_err <= 1'b0;
        end else begin
            cyc_err <= err_d;
            io_wstb <= '0;
            if (ale) begin
                addr_q <= {addr_hi, ad_in};
                iom_q  <= iom_;
                ad_oe  <= 1'b0;
            end
            if (load) begin
                wr_q <= !wr_;
            end
            if (xfer_go) begin
                if (is_wr) begin
                    if (iom_q) begin
                        for (int p = 0; p < IOPORTS; p++) begin
                            if (port == PW'(p)) begin
                                io_out[p*DATASIZE +: DATASIZE] <= ad_in;
                                io_wstb[p]                     <= 1'b1;
                            end
                        end
                    end
                end else begin
                    ad_out <= iom_q ? io_rd : mem[mem_idx];
                    ad_oe  <= 1'b1;
                end
            end
            if (state == XFER && !ale && rd_ && wr_) begin
                ad_oe <= 1'b0;
            end
        end
    end

    // Memory is not reset; xfer_go is gated by the reset-held state, so a
    // reset during a cycle can never commit a write.
    always_ff @(posedge clk) begin
        if (xfer_go && is_wr && !iom_q) begin
            mem[mem_idx] <= ad_in;
        end
    end

endmodule

// File: tb/tb_bus85_memif.sv
// tb/tb_bus85_memif.sv - self-checking bench for bus85_memif at WAITS 0, 3 and 5
module tb_bus85_memif;

    logic        clk = 1'b0;
    logic [2:0]  rst_v = 3'b000;
    logic [7:0]  ad_in = '0;
    logic [7:0]  addr_hi = '0;
    logic        ale = 1'b0, iom_ = 1'b0, rd_ = 1'b1, wr_ = 1'b1;
    logic [31:0] io_in = '0;

    logic [7:0]  ad_out_v  [3];
    logic [31:0] io_out_v  [3];
    logic [3:0]  io_wstb_v [3];
    logic [2:0]  ad_oe_v, ready_v, cyc_err_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WV = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        bus85_memif #(
            .ADDRSIZE(16), .DATASIZE(8), .MEMDEPTH(1024),
            .MEMBASE(0), .WAITS(WV), .IOPORTS(4)
        ) u_dut (
            .clk(clk), .rst_(rst_v[g]), .ad_in(ad_in), .addr_hi(addr_hi),
            .ale(ale), .iom_(iom_), .rd_(rd_), .wr_(wr_),
            .ad_out(ad_out_v[g]), .ad_oe(ad_oe_v[g]), .ready(ready_v[g]),
            .io_in(io_in), .io_out(io_out_v[g]), .io_wstb(io_wstb_v[g]),
            .cyc_err(cyc_err_v[g])
        );
    end

    function automatic int wt(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int dv, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h want 0x%0h", nm, dv, act, exp);
        end
    endtask

    // Reference model: per-DUT memory image and port registers.
    logic [7:0]  mm   [3][1024];
    logic [31:0] io_m [3];

    task automatic model_op(input int dv, input logic io, input logic [15:0] a, input logic wr,
                            input logic both, input logic [7:0] d,
                            output logic e_err, output logic e_rd, output logic [7:0] e_data,
                            output logic [3:0] e_wstb);
        int addr;
        int port;
        addr   = a;
        port   = a[7:0];
        e_err  = 1'b0;
        e_rd   = 1'b0;
        e_data = '0;
        e_wstb = '0;
        if (both) begin
            e_err = 1'b1;
        end else if (io) begin
            if (port >= 4) e_err = 1'b1;
            else if (wr) begin
                io_m[dv][port*8 +: 8] = d;
                e_wstb = 4'b0001 << port;
            end else begin
                e_rd   = 1'b1;
                e_data = io_in[port*8 +: 8];
            end
        end else if (addr >= 0 && addr < 0 + 1024) begin
            if (wr) mm[dv][addr] = d;
            else begin
                e_rd   = 1'b1;
                e_data = mm[dv][addr];
            end
        end else begin
            e_err = 1'b1;
        end
    endtask

    int         obs_err[3], obs_low[3], obs_first[3], obs_oecnt[3], obs_after[3], obs_wcnt[3];
    logic [7:0] obs_data[3];
    logic [3:0] obs_wval[3];

    task automatic sample(input int k);
        for (int i = 0; i < 3; i++) begin
            if (cyc_err_v[i]) obs_err[i]++;
            if (!ready_v[i]) obs_low[i]++;
            if (ad_oe_v[i]) begin
                obs_oecnt[i]++;
                if (obs_first[i] < 0) begin
                    obs_first[i] = k;
                    obs_data[i]  = ad_out_v[i];
                end
            end
            if (io_wstb_v[i] != 4'b0) begin
                obs_wcnt[i]++;
                obs_wval[i] = obs_wval[i] | io_wstb_v[i];
            end
        end
    endtask

    // One bus cycle: ALE edge N, strobe seen from N+1 through N+6, released for edge N+7.
    task automatic bus_op(input logic io, input logic [15:0] a, input logic wr,
                          input logic both, input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            obs_err[i] = 0; obs_low[i] = 0; obs_first[i] = -1; obs_oecnt[i] = 0;
            obs_after[i] = 0; obs_wcnt[i] = 0; obs_data[i] = '0; obs_wval[i] = '0;
        end
        @(negedge clk);
        ale = 1'b1; iom_ = io; addr_hi = a[15:8]; ad_in = a[7:0];
        @(negedge clk);
        ale = 1'b0; ad_in = d;
        if (both) begin rd_ = 1'b0; wr_ = 1'b0; end
        else if (wr) wr_ = 1'b0;
        else rd_ = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            sample(k);
        end
        @(negedge clk);
        rd_ = 1'b1; wr_ = 1'b1;
        @(posedge clk); #1;
        sample(6);
        for (int i = 0; i < 3; i++) obs_after[i] = ad_oe_v[i];
    endtask

    task automatic check_dut(input string nm, input int dv, input logic e_err, input logic e_rd,
                             input logic [7:0] e_data, input logic [3:0] e_wstb);
        int w;
        w = wt(dv);
        chk({nm, "/cyc_err"}, dv, obs_err[dv], e_err);
        chk({nm, "/ready_low"}, dv, obs_low[dv], e_err ? 0 : w);
        chk({nm, "/first_oe"}, dv, obs_first[dv], e_rd ? w : -1);
        if (e_rd) begin
            chk({nm, "/rdata"}, dv, obs_data[dv], e_data);
            chk({nm, "/oe_cycles"}, dv, obs_oecnt[dv], 6 - w);
        end
        chk({nm, "/oe_after"}, dv, obs_after[dv], 0);
        chk({nm, "/wstb_cnt"}, dv, obs_wcnt[dv], (e_wstb != 4'b0) ? 1 : 0);
        chk({nm, "/wstb_val"}, dv, obs_wval[dv], e_wstb);
        chk({nm, "/io_out"}, dv, io_out_v[dv], io_m[dv]);
    endtask

    task automatic run_op(input string nm, input logic io, input logic [15:0] a, input logic wr,
                          input logic both, input logic [7:0] d);
        logic       e_err, e_rd;
        logic [7:0] e_data;
        logic [3:0] e_wstb;
        bus_op(io, a, wr, both, d);
        for (int dv = 0; dv < 3; dv++) begin
            model_op(dv, io, a, wr, both, d, e_err, e_rd, e_data, e_wstb);
            check_dut(nm, dv, e_err, e_rd, e_data, e_wstb);
        end
    endtask

    typedef struct {
        logic        io;
        logic [15:0] a;
        logic        wr;
        logic        both;
        logic [7:0]  d;
        logic        e_err;
        logic        e_rd;
        logic [7:0]  e_data;
        logic [3:0]  e_wstb;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic       m_err, m_rd;
        logic [7:0] m_data, pv, nv;
        logic [3:0] m_wstb;

        tbl[0]  = '{1'b0, 16'h0010, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 4'b0000};
        tbl[1]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'b0000};
        tbl[2]  = '{1'b0, 16'h03FF, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 4'b0000};
        tbl[3]  = '{1'b0, 16'h03FF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 4'b0000};
        tbl[4]  = '{1'b0, 16'h0400, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000};
        tbl[5]  = '{1'b0, 16'h0400, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 4'b0000};
        tbl[6]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b0100};
        tbl[7]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 4'b0000};
        tbl[8]  = '{1'b1, 16'h1201, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 4'b0000};
        tbl[9]  = '{1'b0, 16'h0010, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 4'b0000};
        tbl[10] = '{1'b0, 16'h0010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'b0000};
        tbl[11] = '{1'b1, 16'h0000, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00, 4'b0001};
        tbl[12] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000};
        for (int i = 0; i < 3; i++) io_m[i] = '0;

        // Reset held, then released with strobes idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_v = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int dv = 0; dv < 3; dv++) begin
            chk("reset/ready", dv, ready_v[dv], 1);
            chk("reset/ad_oe", dv, ad_oe_v[dv], 0);
            chk("reset/io_out", dv, io_out_v[dv], 0);
            chk("reset/cyc_err", dv, cyc_err_v[dv], 0);
        end

        // Directed vectors.
        io_in = 32'hD4C3_B2A1;
        for (int t = 0; t < 13; t++) begin
            bus_op(tbl[t].io, tbl[t].a, tbl[t].wr, tbl[t].both, tbl[t].d);
            for (int dv = 0; dv < 3; dv++) begin
                model_op(dv, tbl[t].io, tbl[t].a, tbl[t].wr, tbl[t].both, tbl[t].d,
                         m_err, m_rd, m_data, m_wstb);
                check_dut($sformatf("vec%0d", t), dv, tbl[t].e_err, tbl[t].e_rd,
                          tbl[t].e_data, tbl[t].e_wstb);
            end
        end
        for (int dv = 0; dv < 3; dv++) chk("vec/io_out_final", dv, io_out_v[dv], 32'h003C_000F);

        // Fill low memory so random reads have defined data.
        for (int k = 0; k < 64; k++) run_op("prefill", 1'b0, 16'(k), 1'b1, 1'b0, 8'(k * 37 + 11));

        // New ALE during WAIT: the read of 0x0005 is dropped, 0x0007 is served.
        @(negedge clk);
        ale = 1'b1; iom_ = 1'b0; addr_hi = 8'h00; ad_in = 8'h05;
        @(negedge clk);
        ale = 1'b0; rd_ = 1'b0;
        @(negedge clk);
        ad_in = 8'h07; ale = 1'b1;
        @(negedge clk);
        for (int dv = 0; dv < 3; dv++) chk("abort/oe_dropped", dv, ad_oe_v[dv], 0);
        ale = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int dv = 0; dv < 3; dv++) begin
            chk("abort/oe", dv, ad_oe_v[dv], 1);
            chk("abort/rdata", dv, ad_out_v[dv], mm[dv][7]);
        end
        rd_ = 1'b1;
        repeat (2) @(posedge clk);

        // Reset of the WAITS=5 target in WAIT: its write to 0x0020 must not land.
        pv = mm[2][32];
        nv = ~pv;
        @(negedge clk);
        ale = 1'b1; iom_ = 1'b0; addr_hi = 8'h00; ad_in = 8'h20;
        @(negedge clk);
        ale = 1'b0; ad_in = nv; wr_ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wait/ready_before", 2, ready_v[2], 0);
        rst_v[2] = 1'b0;
        #1;
        chk("rst_wait/ready_async", 2, ready_v[2], 1);
        chk("rst_wait/ad_oe_async", 2, ad_oe_v[2], 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        wr_ = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b1;
        mm[0][32] = nv;
        mm[1][32] = nv;
        io_m[2] = '0;
        run_op("rst_wait/readback", 1'b0, 16'h0020, 1'b0, 1'b0, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 120; n++) begin
            logic        r_io, r_wr, r_both;
            logic [15:0] r_a;
            io_in  = $urandom;
            r_io   = ($urandom_range(0, 2) == 0);
            r_wr   = $urandom_range(0, 1) == 1;
            r_both = ($urandom_range(0, 9) == 0);
            if (r_io) r_a = {8'($urandom), 8'($urandom_range(0, 7))};
            else if ($urandom_range(0, 3) != 0) r_a = 16'($urandom_range(0, 63));
            else r_a = 16'($urandom_range(16'h0400, 16'hFFFF));
            run_op($sformatf("rand%0d", n), r_io, r_a, r_wr, r_both, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
